// File: rtl/double_dabble_iterative_if.sv
// Handshake bundle for the iterative binary-to-BCD converter.
// The slave side is the converter; the master side feeds operands and consumes results.
interface double_dabble_iterative_if #(
  parameter int Input_Bit_Width = 16
);
  localparam int Total_Nibbles = (Input_Bit_Width / 3) + 1;

  logic [Input_Bit_Width-1:0] bin;
  logic                       bin_valid;
  logic                       bin_ready;
  logic [Total_Nibbles*4-1:0] nibbles_out;
  logic [Total_Nibbles-1:0]   nibbles_valid;
  logic                       negative;
  logic                       out_valid;
  logic                       out_ready;

  modport master (
    output bin, bin_valid, out_ready,
    input  bin_ready, nibbles_out, nibbles_valid, negative, out_valid
  );

  modport slave (
    input  bin, bin_valid, out_ready,
    output bin_ready, nibbles_out, nibbles_valid, negative, out_valid
  );
endinterface

// File: rtl/double_dabble_iterative.sv
// Multi-cycle double-dabble converter: one add-3/shift step per enabled cycle on a
// shared datapath, with valid/ready on both sides, optional signed input and zero blanking.
module double_dabble_iterative #(
  parameter int Input_Bit_Width = 16,
  parameter int Signed_Mode     = 0
) (
  input logic clk,
  input logic sync_rst_n,
  input logic clk_en,
  double_dabble_iterative_if.slave bus
);
  localparam int Total_Nibbles = (Input_Bit_Width / 3) + 1;
  localparam int BcdWidth      = Total_Nibbles * 4;
  localparam int CntWidth      = $clog2(Input_Bit_Width + 1);
  localparam logic [CntWidth-1:0] LastIter = CntWidth'(Input_Bit_Width - 1);

  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

  state_t state, next_state;

  logic [Input_Bit_Width-1:0]          shift_reg, shift_next, magnitude;
  logic [BcdWidth-1:0]                 bcd_reg, bcd_adj, bcd_next;
  logic [BcdWidth+Input_Bit_Width-1:0] shifted;
  logic [CntWidth-1:0]                 iter_cnt;
  logic                                neg_pending, load, nz_seen;
  logic [BcdWidth-1:0]                 nibbles_q;
  logic [Total_Nibbles-1:0]            nv_q, nv_next;
  logic                                neg_q;

  assign bus.bin_ready     = clk_en && ((state == IDLE) || ((state == DONE) && bus.out_ready));
  assign bus.out_valid     = (state == DONE);
  assign bus.nibbles_out   = nibbles_q;
  assign bus.nibbles_valid = nv_q;
  assign bus.negative      = (Signed_Mode != 0) ? neg_q : 1'b0;
  assign load              = bus.bin_ready && bus.bin_valid;

  always_ff @(posedge clk) begin
    if (!sync_rst_n)
      state <= IDLE;
    else if (clk_en)
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.bin_valid) next_state = CONVERT;
      CONVERT: if (iter_cnt == LastIter) next_state = DONE;
      DONE:    if (bus.out_ready) next_state = bus.bin_valid ? CONVERT : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Magnitude folding at load lets the most-negative input come out as 2^(W-1).
  always_comb begin
    magnitude = bus.bin;
    if ((Signed_Mode != 0) && bus.bin[Input_Bit_Width-1])
      magnitude = ~bus.bin + Input_Bit_Width'(1);

    bcd_adj = bcd_reg;
    for (int i = 0; i < Total_Nibbles; i++) begin
      if (bcd_reg[i*4 +: 4] >= 4'd5)
        bcd_adj[i*4 +: 4] = bcd_reg[i*4 +: 4] + 4'd3;
    end
    shifted    = {bcd_adj, shift_reg} << 1;
    bcd_next   = shifted[BcdWidth+Input_Bit_Width-1:Input_Bit_Width];
    shift_next = shifted[Input_Bit_Width-1:0];

    nv_next = '0;
    nz_seen = 1'b0;
    for (int i = Total_Nibbles - 1; i >= 0; i--) begin
      nz_seen    = nz_seen | (bcd_next[i*4 +: 4] != 4'd0);
      nv_next[i] = nz_seen;
    end
    nv_next[0] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      shift_reg   <= '0;
      bcd_reg     <= '0;
      iter_cnt    <= '0;
      neg_pending <= 1'b0;
      nibbles_q   <= '0;
      nv_q        <= '0;
      neg_q       <= 1'b0;
    end else if (clk_en) begin
      if (load) begin
        shift_reg   <= magnitude;
        bcd_reg     <= '0;
        iter_cnt    <= '0;
        neg_pending <= (Signed_Mode != 0) && bus.bin[Input_Bit_Width-1];
      end else if (state == CONVERT) begin
        shift_reg <= shift_next;
        bcd_reg   <= bcd_next;
        iter_cnt  <= iter_cnt + 1'b1;
        // Result registers only change on the final iteration, so they hold through IDLE.
        if (iter_cnt == LastIter) begin
          nibbles_q <= bcd_next;
          nv_q      <= nv_next;
          neg_q     <= neg_pending;
        end
      end
    end
  end
endmodule

// File: tb/tb_double_dabble_iterative.sv
// Directed bench for double_dabble_iterative: 8-bit unsigned, 8-bit signed and 16-bit
// unsigned instances sharing clock, reset and enable.
module tb_double_dabble_iterative;
  logic clk = 1'b0;
  logic sync_rst_n;
  logic clk_en;
  int   compared   = 0;
  int   mismatched = 0;
  int   lat;

  always #5 clk = ~clk;

  double_dabble_iterative_if #(.Input_Bit_Width(8))  if8  ();
  double_dabble_iterative_if #(.Input_Bit_Width(8))  ifs8 ();
  double_dabble_iterative_if #(.Input_Bit_Width(16)) if16 ();

  double_dabble_iterative #(.Input_Bit_Width(8), .Signed_Mode(0)) u8_dut (
    .clk(clk), .sync_rst_n(sync_rst_n), .clk_en(clk_en), .bus(if8));
  double_dabble_iterative #(.Input_Bit_Width(8), .Signed_Mode(1)) s8_dut (
    .clk(clk), .sync_rst_n(sync_rst_n), .clk_en(clk_en), .bus(ifs8));
  double_dabble_iterative #(.Input_Bit_Width(16), .Signed_Mode(0)) u16_dut (
    .clk(clk), .sync_rst_n(sync_rst_n), .clk_en(clk_en), .bus(if16));

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic valid_of(input int which);
    case (which)
      0:       return if8.out_valid;
      1:       return ifs8.out_valid;
      default: return if16.out_valid;
    endcase
  endfunction

  // Presents one operand, waits for the acceptance edge, then counts enabled edges to out_valid.
  task automatic applyStimulus(input int which, input logic [15:0] value,
                               input bit toggle_en, output int latency);
    logic en;
    case (which)
      0:       begin if8.bin  = value[7:0]; if8.bin_valid  = 1'b1; end
      1:       begin ifs8.bin = value[7:0]; ifs8.bin_valid = 1'b1; end
      default: begin if16.bin = value;      if16.bin_valid = 1'b1; end
    endcase
    step();
    if8.bin_valid  = 1'b0;
    ifs8.bin_valid = 1'b0;
    if16.bin_valid = 1'b0;
    latency = 0;
    for (int i = 0; i < 100 && !valid_of(which); i++) begin
      if (toggle_en) clk_en = ~clk_en;
      en = clk_en;
      step();
      if (en) latency++;
    end
    clk_en = 1'b1;
  endtask

  initial begin
    clk_en     = 1'b1;
    sync_rst_n = 1'b0;
    if8.bin  = '0; if8.bin_valid  = 1'b0; if8.out_ready  = 1'b1;
    ifs8.bin = '0; ifs8.bin_valid = 1'b0; ifs8.out_ready = 1'b1;
    if16.bin = '0; if16.bin_valid = 1'b0; if16.out_ready = 1'b1;
    step();
    step();

    checkOutput("rst_out_valid", 32'(if8.out_valid), 32'd0);
    checkOutput("rst_nibbles", 32'(if8.nibbles_out), 32'h000);
    checkOutput("rst_nv", 32'(if8.nibbles_valid), 32'd0);
    checkOutput("rst_negative", 32'(ifs8.negative), 32'd0);
    checkOutput("rst_out_valid16", 32'(if16.out_valid), 32'd0);

    sync_rst_n = 1'b1;
    #1;
    checkOutput("idle_bin_ready", 32'(if8.bin_ready), 32'd1);
    clk_en = 1'b0;
    #1;
    checkOutput("bin_ready_clk_en_low", 32'(if8.bin_ready), 32'd0);
    clk_en = 1'b1;
    #1;

    applyStimulus(0, 16'd255, 1'b0, lat);
    checkOutput("u8_255_latency", 32'(lat), 32'd8);
    checkOutput("u8_255_nibbles", 32'(if8.nibbles_out), 32'h255);
    checkOutput("u8_255_nv", 32'(if8.nibbles_valid), 32'b111);

    applyStimulus(0, 16'd0, 1'b0, lat);
    checkOutput("u8_0_latency", 32'(lat), 32'd8);
    checkOutput("u8_0_nibbles", 32'(if8.nibbles_out), 32'h000);
    checkOutput("u8_0_nv", 32'(if8.nibbles_valid), 32'b001);
    checkOutput("u8_0_negative", 32'(if8.negative), 32'd0);

    applyStimulus(1, 16'h0080, 1'b0, lat);
    checkOutput("s8_m128_nibbles", 32'(ifs8.nibbles_out), 32'h128);
    checkOutput("s8_m128_nv", 32'(ifs8.nibbles_valid), 32'b111);
    checkOutput("s8_m128_negative", 32'(ifs8.negative), 32'd1);

    applyStimulus(1, 16'h00F9, 1'b0, lat);
    checkOutput("s8_m7_nibbles", 32'(ifs8.nibbles_out), 32'h007);
    checkOutput("s8_m7_nv", 32'(ifs8.nibbles_valid), 32'b001);
    checkOutput("s8_m7_negative", 32'(ifs8.negative), 32'd1);

    applyStimulus(1, 16'h0005, 1'b0, lat);
    checkOutput("s8_p5_nibbles", 32'(ifs8.nibbles_out), 32'h005);
    checkOutput("s8_p5_negative", 32'(ifs8.negative), 32'd0);

    // Back-to-back 16-bit: 1000 waits in CONVERT and is taken on the edge 65535 is consumed.
    if16.bin = 16'd65535;
    if16.bin_valid = 1'b1;
    step();
    if16.bin = 16'd1000;
    checkOutput("u16_convert_bin_ready", 32'(if16.bin_ready), 32'd0);
    lat = 0;
    for (int i = 0; i < 100 && !if16.out_valid; i++) begin
      step();
      lat++;
    end
    checkOutput("u16_65535_latency", 32'(lat), 32'd16);
    checkOutput("u16_65535_nibbles", 32'(if16.nibbles_out), 32'h065535);
    checkOutput("u16_65535_nv", 32'(if16.nibbles_valid), 32'b011111);
    checkOutput("u16_done_bin_ready", 32'(if16.bin_ready), 32'd1);
    step();
    checkOutput("u16_b2b_out_valid", 32'(if16.out_valid), 32'd0);
    checkOutput("u16_b2b_bin_ready", 32'(if16.bin_ready), 32'd0);
    if16.bin_valid = 1'b0;
    if16.bin = 16'd0;
    lat = 0;
    for (int i = 0; i < 100 && !if16.out_valid; i++) begin
      step();
      lat++;
    end
    checkOutput("u16_1000_latency", 32'(lat), 32'd16);
    checkOutput("u16_1000_nibbles", 32'(if16.nibbles_out), 32'h001000);
    checkOutput("u16_1000_nv", 32'(if16.nibbles_valid), 32'b001111);

    if8.out_ready = 1'b0;
    applyStimulus(0, 16'd99, 1'b0, lat);
    checkOutput("bp_latency", 32'(lat), 32'd8);
    if8.bin = 8'd7;
    if8.bin_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      checkOutput("bp_out_valid", 32'(if8.out_valid), 32'd1);
      checkOutput("bp_nibbles", 32'(if8.nibbles_out), 32'h099);
      checkOutput("bp_bin_ready", 32'(if8.bin_ready), 32'd0);
    end
    clk_en = 1'b0;
    if8.out_ready = 1'b1;
    step();
    step();
    step();
    checkOutput("bp_hold_clk_en_low", 32'(if8.out_valid), 32'd1);
    clk_en = 1'b1;
    if8.bin_valid = 1'b0;
    step();
    checkOutput("bp_released_out_valid", 32'(if8.out_valid), 32'd0);
    checkOutput("idle_hold_nibbles", 32'(if8.nibbles_out), 32'h099);
    checkOutput("idle_hold_nv", 32'(if8.nibbles_valid), 32'b011);

    applyStimulus(0, 16'd200, 1'b1, lat);
    checkOutput("toggle_latency", 32'(lat), 32'd8);
    checkOutput("toggle_nibbles", 32'(if8.nibbles_out), 32'h200);
    checkOutput("toggle_nv", 32'(if8.nibbles_valid), 32'b111);

    // Abort after three iterations; reset must win even with clk_en low.
    if8.bin = 8'd200;
    if8.bin_valid = 1'b1;
    step();
    if8.bin_valid = 1'b0;
    step();
    step();
    step();
    clk_en = 1'b0;
    sync_rst_n = 1'b0;
    step();
    sync_rst_n = 1'b1;
    clk_en = 1'b1;
    #1;
    checkOutput("abort_out_valid", 32'(if8.out_valid), 32'd0);
    checkOutput("abort_nibbles", 32'(if8.nibbles_out), 32'h000);
    checkOutput("abort_nv", 32'(if8.nibbles_valid), 32'd0);
    checkOutput("abort_bin_ready", 32'(if8.bin_ready), 32'd1);

    applyStimulus(0, 16'd42, 1'b0, lat);
    checkOutput("after_abort_latency", 32'(lat), 32'd8);
    checkOutput("after_abort_nibbles", 32'(if8.nibbles_out), 32'h042);
    checkOutput("after_abort_nv", 32'(if8.nibbles_valid), 32'b011);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
